// File: rtl/dm_arbiter_if.sv
// Shared data-memory port bundle: CPU and I/O requesters plus the memory side.
// master is taken by the arbiter, slave by whatever drives the requests.
interface dm_arbiter_if #(
  parameter int bits     = 32,
  parameter int addrBits = 10
);
  logic                cpu_req;
  logic                cpu_we;
  logic [addrBits-1:0] cpu_addr;
  logic [bits-1:0]     cpu_wdata;
  logic                cpu_gnt;
  logic                cpu_done;
  logic [bits-1:0]     cpu_rdata;

  logic                io_req;
  logic                io_we;
  logic [addrBits-1:0] io_addr;
  logic [bits-1:0]     io_wdata;
  logic                io_gnt;
  logic                io_done;
  logic [bits-1:0]     io_rdata;

  logic                mem_en;
  logic                mem_we;
  logic [addrBits-1:0] mem_addr;
  logic [bits-1:0]     mem_wdata;
  logic [bits-1:0]     mem_rdata;
  logic                busy;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_done, cpu_rdata,
    input  io_req, io_we, io_addr, io_wdata,
    output io_gnt, io_done, io_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_done, cpu_rdata,
    output io_req, io_we, io_addr, io_wdata,
    input  io_gnt, io_done, io_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-requester arbiter for one single-port data memory.
// Round-robin on ties, fixed MEM_LAT read latency, all outputs registered.
module dm_arbiter #(
  parameter int bits     = 32,
  parameter int addrBits = 10,
  parameter int MEM_LAT  = 2
) (
  input  logic         clock,
  input  logic         reset,
  dm_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam logic [2:0] LAST = 3'(MEM_LAT - 1);

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                win_io_q, win_io_d;
  logic                last_io_q, last_io_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [addrBits-1:0] mem_addr_q, mem_addr_d;
  logic [bits-1:0]     mem_wdata_q, mem_wdata_d;
  logic                cpu_gnt_q, cpu_gnt_d;
  logic                io_gnt_q, io_gnt_d;
  logic                cpu_done_q, cpu_done_d;
  logic                io_done_q, io_done_d;
  logic [bits-1:0]     cpu_rdata_q, cpu_rdata_d;
  logic [bits-1:0]     io_rdata_q, io_rdata_d;
  logic                busy_q, busy_d;
  logic                pick_io;

  // io wins when alone, or on a tie when the CPU was served last
  assign pick_io = bus.io_req & (~bus.cpu_req | ~last_io_q);

  // next state and next registered outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_io_d    = win_io_q;
    last_io_d   = last_io_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_gnt_d   = 1'b0;
    io_gnt_d    = 1'b0;
    cpu_done_d  = 1'b0;
    io_done_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    io_rdata_d  = io_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req | bus.io_req) begin
          state_d     = ISSUE;
          win_io_d    = pick_io;
          last_io_d   = pick_io;
          mem_en_d    = 1'b1;
          mem_we_d    = pick_io ? bus.io_we : bus.cpu_we;
          mem_addr_d  = pick_io ? bus.io_addr : bus.cpu_addr;
          mem_wdata_d = pick_io ? bus.io_wdata : bus.cpu_wdata;
          cpu_gnt_d   = ~pick_io;
          io_gnt_d    = pick_io;
        end
      end
      ISSUE: begin
        state_d   = WAIT;
        cnt_d     = 3'd0;
        cpu_gnt_d = ~win_io_q;
        io_gnt_d  = win_io_q;
      end
      WAIT: begin
        cpu_gnt_d = ~win_io_q;
        io_gnt_d  = win_io_q;
        if (cnt_q == LAST) begin
          state_d    = DONE;
          cpu_done_d = ~win_io_q;
          io_done_d  = win_io_q;
          if (!mem_we_q) begin
            if (win_io_q) io_rdata_d = bus.mem_rdata;
            else cpu_rdata_d = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // state and output registers, synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      win_io_q    <= 1'b0;
      last_io_q   <= 1'b1;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_gnt_q   <= 1'b0;
      io_gnt_q    <= 1'b0;
      cpu_done_q  <= 1'b0;
      io_done_q   <= 1'b0;
      cpu_rdata_q <= '0;
      io_rdata_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_io_q    <= win_io_d;
      last_io_q   <= last_io_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_gnt_q   <= cpu_gnt_d;
      io_gnt_q    <= io_gnt_d;
      cpu_done_q  <= cpu_done_d;
      io_done_q   <= io_done_d;
      cpu_rdata_q <= cpu_rdata_d;
      io_rdata_q  <= io_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.cpu_gnt   = cpu_gnt_q;
  assign bus.cpu_done  = cpu_done_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.io_gnt    = io_gnt_q;
  assign bus.io_done   = io_done_q;
  assign bus.io_rdata  = io_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus random traffic
// checked against a transaction-timeline reference model.
module tb_dm_arbiter;

  localparam int L = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dm_arbiter_if #(.bits(32), .addrBits(10)) a  ();
  dm_arbiter_if #(.bits(32), .addrBits(10)) a1 ();
  dm_arbiter_if #(.bits(32), .addrBits(10)) a7 ();

  dm_arbiter #(.bits(32), .addrBits(10), .MEM_LAT(L)) u_dut (
    .clock(clk), .reset(rst), .bus(a.master));
  dm_arbiter #(.bits(32), .addrBits(10), .MEM_LAT(1)) u_l1 (
    .clock(clk), .reset(rst), .bus(a1.master));
  dm_arbiter #(.bits(32), .addrBits(10), .MEM_LAT(7)) u_l7 (
    .clock(clk), .reset(rst), .bus(a7.master));

  int pass_cnt = 0;
  int total = 0;

  logic [31:0] rom [1024];

  // reference model: one transaction timeline, age 0 = ISSUE cycle
  logic        m_act = 1'b0;
  int          m_age = 0;
  logic        m_win_io = 1'b0;
  logic        m_last_io = 1'b1;
  logic        m_we = 1'b0;
  logic [9:0]  m_addr = '0;
  logic [31:0] m_wd = '0;
  logic [31:0] m_rd_cpu = '0;
  logic [31:0] m_rd_io = '0;
  logic        m_pick_io;

  assign m_pick_io = a.cpu_req ? (a.io_req && !m_last_io) : a.io_req;

  always @(posedge clk) begin
    if (rst) begin
      m_act <= 1'b0; m_age <= 0; m_last_io <= 1'b1; m_win_io <= 1'b0;
      m_we <= 1'b0; m_addr <= '0; m_wd <= '0;
      m_rd_cpu <= '0; m_rd_io <= '0;
    end else if (!m_act) begin
      if (a.cpu_req || a.io_req) begin
        m_act <= 1'b1; m_age <= 0;
        m_win_io <= m_pick_io; m_last_io <= m_pick_io;
        m_we <= m_pick_io ? a.io_we : a.cpu_we;
        m_addr <= m_pick_io ? a.io_addr : a.cpu_addr;
        m_wd <= m_pick_io ? a.io_wdata : a.cpu_wdata;
      end
    end else if (m_age == L + 1) begin
      m_act <= 1'b0;
    end else begin
      m_age <= m_age + 1;
      if (m_age == L && !m_we) begin
        if (m_win_io) m_rd_io <= rom[m_addr];
        else m_rd_cpu <= rom[m_addr];
      end
    end
  end

  // memory data is only valid in the last wait cycle; garbage otherwise
  always @(negedge clk) begin
    a.mem_rdata <= (m_act && m_age == L) ? rom[m_addr] : $urandom;
    a1.mem_rdata <= $urandom;
    a7.mem_rdata <= $urandom;
  end

  task automatic idle_inputs();
    a.cpu_req = 0; a.cpu_we = 0; a.cpu_addr = '0; a.cpu_wdata = '0;
    a.io_req = 0; a.io_we = 0; a.io_addr = '0; a.io_wdata = '0;
    a1.cpu_req = 0; a1.cpu_we = 0; a1.cpu_addr = '0; a1.cpu_wdata = '0;
    a1.io_req = 0; a1.io_we = 0; a1.io_addr = '0; a1.io_wdata = '0;
    a7.cpu_req = 0; a7.cpu_we = 0; a7.cpu_addr = '0; a7.cpu_wdata = '0;
    a7.io_req = 0; a7.io_we = 0; a7.io_addr = '0; a7.io_wdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    a.cpu_req = 1; a.io_req = 1;
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({a.cpu_gnt, a.io_gnt, a.cpu_done, a.io_done, a.busy, a.mem_en}
        !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000",
        {a.cpu_gnt, a.io_gnt, a.cpu_done, a.io_done, a.busy, a.mem_en});
    else pass_cnt++;
    total++;
    if ({a.mem_we, a.mem_addr, a.mem_wdata} !== 43'b0)
      $display("FAIL reset_mem: got we=%b addr=%h wd=%h want 0",
        a.mem_we, a.mem_addr, a.mem_wdata);
    else pass_cnt++;
    total++;
    if ({a.cpu_rdata, a.io_rdata} !== 64'b0)
      $display("FAIL reset_rdata: got %h/%h want 0", a.cpu_rdata, a.io_rdata);
    else pass_cnt++;
    idle_inputs();
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_cpu_read();
    int dn = 0;
    int io_bad = 0;
    logic [31:0] rd = '0;
    a.cpu_req = 1; a.cpu_we = 0; a.cpu_addr = 10'h005; a.cpu_wdata = $urandom;
    @(negedge clk);
    a.cpu_req = 0;
    total++;
    if ({a.mem_en, a.cpu_gnt, a.io_gnt, a.mem_we, a.mem_addr}
        !== {4'b1100, 10'h005})
      $display("FAIL rd_issue: got en=%b cg=%b ig=%b we=%b addr=%h",
        a.mem_en, a.cpu_gnt, a.io_gnt, a.mem_we, a.mem_addr);
    else pass_cnt++;
    for (int i = 2; i <= 10; i++) begin
      @(negedge clk);
      if (a.io_gnt || a.io_done || a.io_rdata !== 32'h0) io_bad++;
      if (a.cpu_done && dn == 0) begin dn = i; rd = a.cpu_rdata; end
    end
    total++;
    if (dn != L + 2) $display("FAIL rd_done_cycle: got %0d want %0d", dn, L + 2);
    else pass_cnt++;
    total++;
    if (rd !== 32'hDEADBEEF) $display("FAIL rd_data: got %h want deadbeef", rd);
    else pass_cnt++;
    total++;
    if (io_bad != 0) $display("FAIL rd_io_idle: got %0d busy cycles want 0", io_bad);
    else pass_cnt++;
    total++;
    if (a.cpu_rdata !== 32'hDEADBEEF)
      $display("FAIL rd_hold: got %h want deadbeef", a.cpu_rdata);
    else pass_cnt++;
  endtask

  task automatic test_tie();
    logic [2:0] seq = '0;
    int nis = 0;
    int both = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    a.cpu_req = 1; a.io_req = 1; a.cpu_we = 0; a.io_we = 0;
    a.cpu_addr = 10'($urandom); a.io_addr = 10'($urandom);
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      if (a.cpu_gnt && a.io_gnt) both++;
      if (a.mem_en) begin
        if (nis < 3) seq[nis] = a.io_gnt;
        nis++;
      end
    end
    idle_inputs();
    repeat (6) @(negedge clk);
    total++;
    if (nis != 3) $display("FAIL tie_count: got %0d issues want 3", nis);
    else pass_cnt++;
    total++;
    if (seq !== 3'b010) $display("FAIL tie_order: got %b want 010 (cpu,io,cpu)", seq);
    else pass_cnt++;
    total++;
    if (both != 0) $display("FAIL tie_onehot: got %0d cycles want 0", both);
    else pass_cnt++;
  endtask

  task automatic test_io_write();
    logic [31:0] prev;
    int ndone = 0;
    int cdone = 0;
    prev = m_rd_io;
    a.io_req = 1; a.io_we = 1; a.io_addr = 10'h3FF; a.io_wdata = 32'h12345678;
    @(negedge clk);
    a.io_req = 0;
    total++;
    if ({a.mem_en, a.mem_we, a.io_gnt, a.cpu_gnt, a.mem_addr, a.mem_wdata}
        !== {4'b1110, 10'h3FF, 32'h12345678})
      $display("FAIL wr_issue: got en=%b we=%b ig=%b addr=%h wd=%h",
        a.mem_en, a.mem_we, a.io_gnt, a.mem_addr, a.mem_wdata);
    else pass_cnt++;
    for (int i = 2; i <= 9; i++) begin
      @(negedge clk);
      if (a.io_done) ndone++;
      if (a.cpu_done) cdone++;
    end
    total++;
    if (ndone != 1 || cdone != 0)
      $display("FAIL wr_done: got io=%0d cpu=%0d want 1/0", ndone, cdone);
    else pass_cnt++;
    total++;
    if (a.io_rdata !== prev)
      $display("FAIL wr_rdata: got %h want %h", a.io_rdata, prev);
    else pass_cnt++;
  endtask

  task automatic test_drop();
    int dn = 0;
    a.cpu_req = 1; a.cpu_we = 0; a.cpu_addr = 10'($urandom);
    @(negedge clk);
    @(negedge clk);
    a.cpu_req = 0;
    if (a.cpu_done) dn = 2;
    for (int i = 3; i <= 9; i++) begin
      @(negedge clk);
      if (a.cpu_done && dn == 0) dn = i;
    end
    total++;
    if (dn != L + 2) $display("FAIL drop_done: got %0d want %0d", dn, L + 2);
    else pass_cnt++;
  endtask

  task automatic test_reset_wait();
    int nd = 0;
    a.cpu_req = 1; a.cpu_we = 0; a.cpu_addr = 10'h005;
    @(negedge clk);
    a.cpu_req = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    total++;
    if ({a.busy, a.cpu_gnt, a.io_gnt, a.cpu_done, a.io_done, a.mem_en}
        !== 6'b0)
      $display("FAIL rstw_ctrl: got busy=%b cg=%b ig=%b cd=%b id=%b en=%b",
        a.busy, a.cpu_gnt, a.io_gnt, a.cpu_done, a.io_done, a.mem_en);
    else pass_cnt++;
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (a.cpu_done || a.io_done || a.busy) nd++;
    end
    total++;
    if (nd != 0) $display("FAIL rstw_nodone: got %0d active cycles want 0", nd);
    else pass_cnt++;
    total++;
    if ({a.cpu_rdata, a.io_rdata} !== 64'b0)
      $display("FAIL rstw_rdata: got %h/%h want 0", a.cpu_rdata, a.io_rdata);
    else pass_cnt++;
  endtask

  task automatic test_sweep();
    int d1 = 0;
    int d7 = 0;
    int both = 0;
    a1.cpu_req = 1; a1.io_req = 1; a7.cpu_req = 1; a7.io_req = 1;
    a1.cpu_addr = 10'($urandom); a7.io_addr = 10'($urandom);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) begin
        a1.cpu_req = 0; a1.io_req = 0; a7.cpu_req = 0; a7.io_req = 0;
      end
      if ((a1.cpu_gnt && a1.io_gnt) || (a7.cpu_gnt && a7.io_gnt)) both++;
      if ((a1.cpu_done || a1.io_done) && d1 == 0) d1 = i;
      if ((a7.cpu_done || a7.io_done) && d7 == 0) d7 = i;
    end
    total++;
    if (d1 != 3) $display("FAIL sweep_lat1: got %0d want 3", d1);
    else pass_cnt++;
    total++;
    if (d7 != 9) $display("FAIL sweep_lat7: got %0d want 9", d7);
    else pass_cnt++;
    total++;
    if (both != 0) $display("FAIL sweep_onehot: got %0d cycles want 0", both);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [5:0]  ec, gc;
    logic [42:0] em, gm;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      ec = {m_act && !m_win_io, m_act && m_win_io,
            m_act && !m_win_io && m_age == L + 1,
            m_act && m_win_io && m_age == L + 1,
            m_act, m_act && m_age == 0};
      gc = {a.cpu_gnt, a.io_gnt, a.cpu_done, a.io_done, a.busy, a.mem_en};
      total++;
      if (gc !== ec) $display("FAIL rnd_ctrl@%0d: got %b want %b", i, gc, ec);
      else pass_cnt++;
      em = {m_we, m_addr, m_wd};
      gm = {a.mem_we, a.mem_addr, a.mem_wdata};
      total++;
      if (gm !== em) $display("FAIL rnd_mem@%0d: got %h want %h", i, gm, em);
      else pass_cnt++;
      total++;
      if ({a.cpu_rdata, a.io_rdata} !== {m_rd_cpu, m_rd_io})
        $display("FAIL rnd_rdata@%0d: got %h/%h want %h/%h", i,
          a.cpu_rdata, a.io_rdata, m_rd_cpu, m_rd_io);
      else pass_cnt++;
      a.cpu_req = ($urandom_range(0, 2) != 0);
      a.io_req = ($urandom_range(0, 2) != 0);
      a.cpu_we = $urandom_range(0, 1) == 1;
      a.io_we = $urandom_range(0, 1) == 1;
      a.cpu_addr = 10'($urandom); a.io_addr = 10'($urandom);
      a.cpu_wdata = $urandom; a.io_wdata = $urandom;
    end
    idle_inputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    rom[5] = 32'hDEADBEEF;
    idle_inputs();
    test_reset();
    test_cpu_read();
    test_tie();
    test_io_write();
    test_drop();
    test_reset_wait();
    test_sweep();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameters SHALL be: bits, default 32, data width; addrBits, default 10, address width; MEM_LAT, default 2, memory read latency in cycles, legal range 1..7.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request, level.
- cpu_we  in  1  CPU write enable.
- cpu_addr  in  addrBits  CPU address.
- cpu_wdata  in  bits  CPU write data.
- cpu_gnt  out  1  CPU owns the memory.
- cpu_done  out  1  one-cycle CPU completion pulse.
- cpu_rdata  out  bits  CPU read data.
- io_req, io_we, io_addr, io_wdata  in  1/1/addrBits/bits  I/O requester; same meaning as the CPU inputs.
- io_gnt, io_done, io_rdata  out  1/1/bits  I/O requester; same meaning as the CPU outputs.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_addr  out  addrBits  memory address.
- mem_wdata  out  bits  memory write data.
- mem_rdata  in  bits  memory read data.
- busy  out  1  high whenever the state is not IDLE.

Function
REQ-003 All outputs SHALL be registered, and the block SHALL share one single-port data memory between the CPU and the I/O requester.
REQ-004 FSM states SHALL be IDLE, ISSUE, WAIT and DONE.
REQ-005 IDLE transitions: any req sampled high -> ISSUE; otherwise stay in IDLE.
REQ-006 Arbitration in IDLE: if only one req is high, that requester wins; if both are high, the requester not served last wins; a last-served pointer updates on each ISSUE.
REQ-007 ISSUE SHALL last exactly 1 cycle with mem_en=1 and winner gnt=1; mem_we, mem_addr and mem_wdata SHALL carry the winner's values, latched at the IDLE->ISSUE edge.
REQ-008 WAIT SHALL last exactly MEM_LAT cycles, counted by a 3-bit counter, with mem_en=0 and gnt held.
REQ-009 mem_rdata SHALL be valid during the last WAIT cycle and SHALL be captured into the winner's rdata at the end of that cycle, for reads only.
REQ-010 Writes SHALL leave both rdata registers unchanged.
REQ-011 DONE SHALL last 1 cycle with winner done=1 and gnt=1, then always go to IDLE; a req high during DONE is not arbitrated until IDLE.
REQ-012 Timing: req sampled at edge k -> ISSUE in cycle k+1 -> done in cycle k+2+MEM_LAT; throughput is one access per MEM_LAT+3 cycles.
REQ-013 The loser's gnt and done SHALL stay 0 for the whole transaction; its req SHALL remain pending and win the next IDLE arbitration.
REQ-014 A req dropped after ISSUE SHALL NOT abort the transaction; DONE and done still occur.
REQ-015 Inputs changing after the latch edge SHALL NOT affect the transaction in flight.
REQ-016 rdata SHALL hold its value until the next read completion on the same port.
REQ-017 At most one gnt SHALL be high at any time, and done SHALL be high only together with the same port's gnt.

Reset
REQ-018 When reset is sampled high, the block SHALL enter IDLE.
REQ-019 Reset SHALL clear all outputs to 0, including both rdata registers and the mem_* outputs.
REQ-020 Reset SHALL clear the wait counter to 0 and set the last-served pointer to io, so the CPU wins the first tie.
REQ-021 Reset SHALL take priority over all other inputs.
REQ-022 Reset in ISSUE, WAIT or DONE SHALL abandon the access with no done pulse and no rdata update.

Verification
REQ-023 CPU read, MEM_LAT=2, addr 0x005, mem_rdata 0xDEADBEEF -> mem_en in cycle k+1, cpu_done in cycle k+4, cpu_rdata=0xDEADBEEF, io_* outputs idle.
REQ-024 cpu_req and io_req both high after reset -> CPU served first, then io_gnt at the following ISSUE without io_req dropping; back-to-back ties alternate CPU, IO, CPU.
REQ-025 io write addr 0x3FF, wdata 0x12345678 -> mem_we=1, mem_addr=0x3FF, mem_wdata=0x12345678 in ISSUE; io_rdata unchanged; io_done pulses once.
REQ-026 cpu_req dropped in the first WAIT cycle -> cpu_done still pulses at k+4.
REQ-027 Reset asserted in WAIT -> next cycle IDLE, busy=0, no done pulse, rdata=0.
REQ-028 MEM_LAT=1 and MEM_LAT=7 sweep -> done at k+3 and k+9 respectively; at most one gnt high in every cycle.
